// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types for the imem/dmem memory-port arbiter: the
//                request record carried through the pending slots and onto
//                the downstream port, and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // One memory request as seen on the downstream port.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    // Arbiter state; BUSY_x names the side owning the in-flight request.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam mem_req_t c_REQ_NONE = '0;

    // A request is present when either mask carries at least one lane.
    function automatic logic req_active(input mem_req_t req);
        return (|req.rmask) | (|req.wmask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_slot.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_slot
//  Description : Single-entry pending-request register for one requester.
//                i_load captures i_load_req and marks the slot valid;
//                i_consume empties it. Consume takes priority: the top level
//                only consumes and loads together when a fresh pulse is
//                granted straight through, which must not leave a stale copy.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_load, i_load_req - capture a new request
//                i_consume         - request has been issued downstream
//                o_valid, o_req    - slot occupancy and stored request
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_slot
    import mem_port_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  mem_req_t i_load_req,
    input  logic     i_consume,
    output logic     o_valid,
    output mem_req_t o_req
);

    logic     r_valid;
    mem_req_t r_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_req   <= c_REQ_NONE;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_req   <= i_load_req;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one word-wide memory port between the instruction
//                fetch requester (imem) and the data requester (dmem).
//                Request pulses are captured in one slot per side, serialised
//                onto mem_* (registered) and held until mem_resp; the owner
//                then gets rdata plus a one-cycle resp pulse.
//  Parameters  : RR_MODE - 0: dmem wins ties; 1: round-robin, dmem first
//  Ports       : clk, rst                 - clock, sync active-high reset
//                imem_addr/rmask          - fetch request pulse
//                imem_rdata/resp          - fetch completion
//                dmem_addr/rmask/wmask/wdata - data request pulse
//                dmem_rdata/resp          - data completion
//                mem_addr/rmask/wmask/wdata - downstream request (held)
//                mem_rdata/resp           - downstream completion
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RR_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t  r_state;
    mem_req_t    r_mem_req;
    logic        r_imem_resp, r_dmem_resp;
    logic [31:0] r_imem_rdata, r_dmem_rdata;

    mem_req_t w_imem_in, w_dmem_in, w_imem_slot, w_dmem_slot;
    mem_req_t w_imem_req, w_dmem_req;
    logic     w_imem_pulse, w_dmem_pulse;
    logic     w_imem_valid, w_dmem_valid;
    logic     w_imem_pend, w_dmem_pend;
    logic     w_free, w_pick_d, w_grant_i, w_grant_d;

    // A pulse arriving while the port is free is granted in the same cycle
    // (bypassing the slot) so mem_* is valid one cycle after the pulse.
    always_comb begin
        w_imem_in    = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'b0, wdata: 32'b0};
        w_dmem_in    = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
        w_imem_pulse = req_active(w_imem_in);
        w_dmem_pulse = req_active(w_dmem_in);
        w_imem_pend  = w_imem_valid | w_imem_pulse;
        w_dmem_pend  = w_dmem_valid | w_dmem_pulse;
        w_imem_req   = w_imem_valid ? w_imem_slot : w_imem_in;
        w_dmem_req   = w_dmem_valid ? w_dmem_slot : w_dmem_in;
        // The completing cycle already arbitrates, so grants run back to back.
        w_free       = (r_state == IDLE) | mem_resp;
        w_grant_d    = w_free & w_dmem_pend & w_pick_d;
        w_grant_i    = w_free & w_imem_pend & ~w_pick_d;
    end

    generate
        if (RR_MODE != 0) begin : g_rr
            // Set when dmem should win the next tie.
            logic r_rr_dmem;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rr_dmem <= 1'b1;
                end else if (w_grant_d) begin
                    r_rr_dmem <= 1'b0;
                end else if (w_grant_i) begin
                    r_rr_dmem <= 1'b1;
                end
            end

            assign w_pick_d = (w_imem_pend & w_dmem_pend) ? r_rr_dmem : w_dmem_pend;
        end else begin : g_fixed
            assign w_pick_d = w_dmem_pend;
        end
    endgenerate

    mem_req_slot u_imem_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_imem_pulse),
        .i_load_req (w_imem_in),
        .i_consume  (w_grant_i),
        .o_valid    (w_imem_valid),
        .o_req      (w_imem_slot)
    );

    mem_req_slot u_dmem_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_dmem_pulse),
        .i_load_req (w_dmem_in),
        .i_consume  (w_grant_d),
        .o_valid    (w_dmem_valid),
        .o_req      (w_dmem_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_req    <= c_REQ_NONE;
            r_imem_resp  <= 1'b0;
            r_dmem_resp  <= 1'b0;
            r_imem_rdata <= 32'b0;
            r_dmem_rdata <= 32'b0;
        end else begin
            r_imem_resp <= 1'b0;
            r_dmem_resp <= 1'b0;

            // mem_resp only counts while a request is in flight.
            if (mem_resp && r_state == BUSY_I) begin
                r_imem_resp  <= 1'b1;
                r_imem_rdata <= mem_rdata;
            end
            if (mem_resp && r_state == BUSY_D) begin
                r_dmem_resp  <= 1'b1;
                r_dmem_rdata <= mem_rdata;
            end

            if (w_free) begin
                if (w_grant_d) begin
                    r_state   <= BUSY_D;
                    r_mem_req <= w_dmem_req;
                end else if (w_grant_i) begin
                    r_state   <= BUSY_I;
                    r_mem_req <= w_imem_req;
                end else begin
                    // Nothing to issue: drop the masks, address/data may linger.
                    r_state         <= IDLE;
                    r_mem_req.rmask <= 4'b0;
                    r_mem_req.wmask <= 4'b0;
                end
            end
        end
    end

    assign mem_addr   = r_mem_req.addr;
    assign mem_rmask  = r_mem_req.rmask;
    assign mem_wmask  = r_mem_req.wmask;
    assign mem_wdata  = r_mem_req.wdata;
    assign imem_resp  = r_imem_resp;
    assign imem_rdata = r_imem_rdata;
    assign dmem_resp  = r_dmem_resp;
    assign dmem_rdata = r_dmem_rdata;

endmodule
`default_nettype wire
